pipe_stall_ctrl: RTL
====================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameters: REGFILE_ADDR_WIDTH, default 5, register address width; MEM_TIMEOUT, default 255, max memory wait cycles; CNT_WIDTH, default 16, stall counter width.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- ex_is_load  in  1  EX-stage instruction is a load
- ex_WR_en  in  1  EX-stage instruction writes the register file
- ex_WR_addr  in  REGFILE_ADDR_WIDTH  EX-stage destination register
- id_rs_addr, id_rt_addr  in  REGFILE_ADDR_WIDTH each  ID-stage source registers
- id_rs_used, id_rt_used  in  1 each  ID-stage source is read
- mem_req  in  1  MEM stage issues a data-memory access
- mem_ack  in  1  data memory completes the access
- branch_taken  in  1  EX stage resolves a taken branch
- halt_req  in  1  request to freeze the core
- resume  in  1  leave HALT
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (WR_en=0)
- halted  out  1  FSM in HALT
- mem_err  out  1  sticky memory timeout flag
- stall_count  out  CNT_WIDTH  saturating stall-cycle count

Function
REQ-003 SHALL implement FSM states HOLD, RUN, MEM_WAIT, HALT; enables/flushes are combinational from state and current inputs; halted, mem_err, stall_count are registered.
REQ-004 HOLD SHALL last exactly one cycle after reset deassertion: all enables 0, all flushes 1, then RUN.
REQ-005 In RUN with mem_req=1 and mem_ack=0, SHALL drive all enables 0, memwb_en=1, memwb_flush=1, and go to MEM_WAIT.
REQ-006 In RUN with mem_req=1 and mem_ack=1 in the same cycle, SHALL not stall.
REQ-007 In MEM_WAIT, SHALL drive the same outputs as REQ-005 until mem_ack=1; in the ack cycle all enables 1, no flush, next state RUN (or HALT if halt_req is pending, REQ-011).
REQ-008 Load-use hazard = ex_is_load & ex_WR_en & ex_WR_addr!=0 & ((id_rs_used & id_rs_addr==ex_WR_addr) | (id_rt_used & id_rt_addr==ex_WR_addr)); in RUN without a memory stall it SHALL drive pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1, for one cycle.
REQ-009 branch_taken SHALL assert ifid_flush=1 and idex_flush=1 with all enables 1, only in cycles where exmem_en=1; while stalled by memory it is held and applied in the release cycle.
REQ-010 Priority: memory stall > branch flush > load-use; branch_taken with load-use drives the REQ-009 response (the load-use consumer is flushed).
REQ-011 halt_req in RUN with no memory stall SHALL enter HALT next cycle; halt_req in MEM_WAIT SHALL be latched and honoured on the ack cycle transition.
REQ-012 In HALT, all enables 0, no flushes, halted=1; resume=1 with mem_err=0 returns to RUN next cycle; resume is ignored while mem_err=1.
REQ-013 A wait counter SHALL clear on MEM_WAIT entry and increment each MEM_WAIT cycle; reaching MEM_TIMEOUT without ack SHALL set mem_err=1 and go to HALT; a late mem_ack is ignored.
REQ-014 stall_count SHALL increment once per cycle with pc_en=0 in RUN or MEM_WAIT, saturating at all-ones.
REQ-015 No otherwise stalled/flushed cycle in RUN: all enables 1, all flushes 0.

Reset
REQ-016 reset SHALL asynchronously force state HOLD, halted=0, mem_err=0, stall_count=0, wait counter 0, pending halt 0; all enables 0 and all flushes 1 while reset=1.
REQ-017 reset asserted mid-MEM_WAIT or mid-HALT SHALL abandon the operation with no residual state.

Structure
REQ-018 FSM state encoding and the default MEM_TIMEOUT constant SHALL live in the shared pipeline package.
REQ-019 Hazard detection (REQ-008) SHALL be a combinational sub-module hazard_detect; FSM and counters stay in pipe_stall_ctrl.

Verification
REQ-020 Load r3 in EX, ID reads rs=r3 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_count=1.
REQ-021 mem_req, ack 3 cycles later -> 3 cycles enables 0 with memwb_flush=1, ack cycle all enables 1; stall_count=3.
REQ-022 branch_taken during 2-cycle memory wait -> no flush during wait; ifid_flush=idex_flush=1 on ack cycle.
REQ-023 MEM_TIMEOUT=4, mem_req, no ack -> mem_err=1, halted=1 after 4 wait cycles; resume ignored; reset clears both.
REQ-024 halt_req in MEM_WAIT, ack 2 cycles later -> HALT after ack; resume -> RUN next cycle.
REQ-025 Load to r0 with ID reading r0 -> no stall.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline control definitions: FSM state encoding, default timing
// constants and the canned enable/flush patterns the stall controller drives.
package pipe_stall_ctrl_pkg;

    // Stall controller FSM states
    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } pipe_state_t;

    localparam int DEFAULT_REGFILE_ADDR_WIDTH = 5;
    localparam int DEFAULT_MEM_TIMEOUT        = 255;
    localparam int DEFAULT_CNT_WIDTH          = 16;

    // One bundle of every pipeline register enable and bubble-insert flush
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } pipe_ctrl_t;

    // Post-reset settle cycle: nothing moves, every register takes a bubble
    localparam pipe_ctrl_t CTRL_HOLD = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b1, idex_flush: 1'b1, memwb_flush: 1'b1
    };

    // Free-running pipeline
    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b0
    };

    // Data memory busy: freeze everything up to MEM, push bubbles into WB
    localparam pipe_ctrl_t CTRL_MEM_STALL = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b1
    };

    // Taken branch: squash the two younger instructions, keep moving
    localparam pipe_ctrl_t CTRL_BRANCH = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1, memwb_flush: 1'b0
    };

    // Load-use: hold PC and IF/ID, insert a bubble into EX, let the load advance
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b1, memwb_flush: 1'b0
    };

    // Frozen core: nothing moves, nothing is squashed
    localparam pipe_ctrl_t CTRL_HALT = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b0
    };

    // Pattern for a cycle in which memory is not stalling: branch beats load-use
    function automatic pipe_ctrl_t run_ctrl(input logic branch, input logic load_use);
        pipe_ctrl_t c;
        if (branch) begin
            c = CTRL_BRANCH;
        end else if (load_use) begin
            c = CTRL_LOAD_USE;
        end else begin
            c = CTRL_RUN;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Combinational load-use hazard detector: flags an ID-stage instruction that
// reads the destination of a load still sitting in EX. r0 never hazards.
module hazard_detect
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_REGFILE_ADDR_WIDTH
) (
    input  logic              i_ex_is_load,
    input  logic              i_ex_wr_en,
    input  logic [ADDR_W-1:0] i_ex_wr_addr,
    input  logic [ADDR_W-1:0] i_id_rs_addr,
    input  logic [ADDR_W-1:0] i_id_rt_addr,
    input  logic              i_id_rs_used,
    input  logic              i_id_rt_used,
    output logic              o_load_use
);

    localparam int NUM_SRC = 2;

    logic [ADDR_W-1:0]  w_src_addr [NUM_SRC];
    logic [NUM_SRC-1:0] w_src_used;
    logic [NUM_SRC-1:0] w_src_match;
    logic               w_load_producer;

    assign w_src_addr[0] = i_id_rs_addr;
    assign w_src_addr[1] = i_id_rt_addr;
    assign w_src_used    = {i_id_rt_used, i_id_rs_used};

    // A load writing a real register is the only producer that can hazard
    assign w_load_producer = i_ex_is_load & i_ex_wr_en & (i_ex_wr_addr != '0);

    // Per-source compare: only operands actually read by ID count
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_src_match[gi] = w_src_used[gi] & (w_src_addr[gi] == i_ex_wr_addr);
        end
    endgenerate

    assign o_load_use = w_load_producer & (|w_src_match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: sequences reset settle, memory wait with
// timeout, halt/resume, and drives per-stage enables and bubble flushes.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int REGFILE_ADDR_WIDTH = DEFAULT_REGFILE_ADDR_WIDTH,
    parameter int MEM_TIMEOUT        = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_WIDTH          = DEFAULT_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ex_is_load,
    input  logic                          ex_WR_en,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ex_WR_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] id_rt_addr,
    input  logic                          id_rs_used,
    input  logic                          id_rt_used,
    input  logic                          mem_req,
    input  logic                          mem_ack,
    input  logic                          branch_taken,
    input  logic                          halt_req,
    input  logic                          resume,
    output logic                          pc_en,
    output logic                          ifid_en,
    output logic                          idex_en,
    output logic                          exmem_en,
    output logic                          memwb_en,
    output logic                          ifid_flush,
    output logic                          idex_flush,
    output logic                          memwb_flush,
    output logic                          halted,
    output logic                          mem_err,
    output logic [CNT_WIDTH-1:0]          stall_count
);

    // Wide enough to hold MEM_TIMEOUT itself
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    pipe_state_t           r_state;
    pipe_state_t           w_state_next;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [WAIT_W-1:0]     w_wait_cnt_next;
    logic [WAIT_W-1:0]     w_wait_inc;
    logic                  r_halt_pend;
    logic                  w_halt_pend_next;
    logic                  r_branch_pend;
    logic                  w_branch_pend_next;
    logic                  r_mem_err;
    logic                  w_mem_err_next;
    logic                  r_halted;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic                  w_stall_inc;
    logic                  w_load_use;
    pipe_ctrl_t            w_ctrl;

    hazard_detect #(
        .ADDR_W (REGFILE_ADDR_WIDTH)
    ) u_hazard_detect (
        .i_ex_is_load (ex_is_load),
        .i_ex_wr_en   (ex_WR_en),
        .i_ex_wr_addr (ex_WR_addr),
        .i_id_rs_addr (id_rs_addr),
        .i_id_rt_addr (id_rt_addr),
        .i_id_rs_used (id_rs_used),
        .i_id_rt_used (id_rt_used),
        .o_load_use   (w_load_use)
    );

    assign w_wait_inc = r_wait_cnt + WAIT_W'(1);

    // Next-state, bookkeeping and enable/flush decode from state and live inputs
    always_comb begin
        w_state_next       = r_state;
        w_ctrl             = CTRL_HOLD;
        w_wait_cnt_next    = r_wait_cnt;
        w_halt_pend_next   = r_halt_pend;
        w_branch_pend_next = r_branch_pend;
        w_mem_err_next     = r_mem_err;

        case (r_state)
            ST_HOLD: begin
                w_ctrl       = CTRL_HOLD;
                w_state_next = ST_RUN;
            end

            ST_RUN: begin
                if (mem_req && !mem_ack) begin
                    // Memory miss wins over everything; remember what else
                    // arrived so it is not lost while the pipe is frozen
                    w_ctrl             = CTRL_MEM_STALL;
                    w_state_next       = ST_MEM_WAIT;
                    w_wait_cnt_next    = '0;
                    w_halt_pend_next   = halt_req;
                    w_branch_pend_next = branch_taken;
                end else begin
                    w_ctrl             = run_ctrl(branch_taken, w_load_use);
                    w_halt_pend_next   = 1'b0;
                    w_branch_pend_next = 1'b0;
                    w_state_next       = halt_req ? ST_HALT : ST_RUN;
                end
            end

            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    // Release cycle: the held branch squash lands here. A
                    // load-use still present must be honoured too, or the
                    // consumer would slip past its producer on release.
                    w_ctrl             = run_ctrl(branch_taken | r_branch_pend, w_load_use);
                    w_halt_pend_next   = 1'b0;
                    w_branch_pend_next = 1'b0;
                    w_state_next       = (halt_req | r_halt_pend) ? ST_HALT : ST_RUN;
                end else begin
                    w_ctrl             = CTRL_MEM_STALL;
                    w_wait_cnt_next    = w_wait_inc;
                    w_halt_pend_next   = r_halt_pend | halt_req;
                    w_branch_pend_next = r_branch_pend | branch_taken;
                    if (w_wait_inc >= WAIT_W'(MEM_TIMEOUT)) begin
                        // Give up on the access; the core freezes until reset
                        w_mem_err_next     = 1'b1;
                        w_halt_pend_next   = 1'b0;
                        w_branch_pend_next = 1'b0;
                        w_state_next       = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                w_ctrl = CTRL_HALT;
                if (resume && !r_mem_err) begin
                    w_state_next = ST_RUN;
                end
            end

            default: begin
                w_ctrl       = CTRL_HOLD;
                w_state_next = ST_HOLD;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Memory wait counter and the requests deferred across a memory stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_halt_pend   <= 1'b0;
            r_branch_pend <= 1'b0;
        end else begin
            r_wait_cnt    <= w_wait_cnt_next;
            r_halt_pend   <= w_halt_pend_next;
            r_branch_pend <= w_branch_pend_next;
        end
    end

    // Registered status: halted tracks the state we are entering, error is sticky
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halted  <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            r_halted  <= (w_state_next == ST_HALT);
            r_mem_err <= w_mem_err_next;
        end
    end

    // Fetch-stalled cycles while the core is live, saturating at all-ones
    assign w_stall_inc = ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) && !w_ctrl.pc_en;

    // Saturating stall-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign pc_en       = w_ctrl.pc_en;
    assign ifid_en     = w_ctrl.ifid_en;
    assign idex_en     = w_ctrl.idex_en;
    assign exmem_en    = w_ctrl.exmem_en;
    assign memwb_en    = w_ctrl.memwb_en;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_flush  = w_ctrl.idex_flush;
    assign memwb_flush = w_ctrl.memwb_flush;
    assign halted      = r_halted;
    assign mem_err     = r_mem_err;
    assign stall_count = r_stall_cnt;

endmodule
